// File: rtl/alu_pkg.sv
// alu_pkg: shared request type and opcode constants for the ALU and its issue stage
package alu_pkg;
    typedef struct packed {
        int a;
        int b;
        bit op;
    } alu_req_t;
    localparam bit ALU_OP_ADD = 1'b0;
    localparam bit ALU_OP_SUB = 1'b1;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit two's complement add/subtract with wrap-around
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] z
);
    // op selects subtract, otherwise add; overflow simply wraps
    always_comb z = (op == ALU_OP_SUB) ? a - b : a + b;
endmodule

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: power-of-two request FIFO; occupancy separates full from empty
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  alu_req_t         wr_req,
    output alu_req_t         head,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    alu_req_t mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    assign head  = mem[rd_ptr];
    assign full  = occupancy == CNT_W'(DEPTH);
    assign empty = occupancy == '0;
    // storage needs no reset; the head is only consumed while occupancy is non-zero
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_req;
    // pointers wrap naturally at DEPTH; the count tracks push minus pop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU requests and registers results under valid/ready flow control
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_op,
    input  logic [31:0]      alu_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [CNT_W-1:0] occupancy,
    output logic [31:0]      issued
);
    alu_req_t req, head;
    logic full, empty, push, issue;
    assign req      = {in_a, in_b, in_op};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!out_valid || out_ready);
    assign alu_a    = empty ? '0 : head.a;
    assign alu_b    = empty ? '0 : head.b;
    assign alu_op   = empty ? 1'b0 : head.op;

    alu_req_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (issue),
        .wr_req   (req),
        .head     (head),
        .occupancy(occupancy),
        .full     (full),
        .empty    (empty)
    );

    // load a result whenever the slot is free or being taken; otherwise hold it stable
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            issued    <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_z     <= alu_z;
            issued    <= issued + 32'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for the issue stage driving a real ALU
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_op = 1'b0;
    logic [31:0] alu_a, alu_b, alu_z;
    logic        alu_op;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [2:0]  occupancy;
    logic [31:0] issued;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        stall_v = 1'b0;
    logic [31:0] stall_z = '0;
    bit          s5 = 1'b0;
    int          max_occ = 0, run = 0, max_run = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .occupancy(occupancy), .issued(issued)
    );

    alu u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .z(alu_z));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [31:0] exp);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout got in_ready=0 want 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // monitor: pop on every accepted result, hold check while stalled, track occupancy
    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
            run = 0;
        end else begin
            if (occupancy > 3'd4) begin
                checks++;
                errors++;
                $display("FAIL occ_bound got %0d want <=4", occupancy);
            end
            if (stall_v && out_valid) chk("stall_hold", out_z, stall_z);
            stall_v = out_valid && !out_ready;
            stall_z = out_z;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", out_z, 32'hxxxxxxxx);
                else chk("out_z", out_z, exp_q.pop_front());
            end
            if (s5) begin
                if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
                run = out_valid ? run + 1 : 0;
                if (run > max_run) max_run = run;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_z", out_z, 32'd0);
        chk("rst_issued", issued, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // mid-stream async reset: one result held, three queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i + 1), 32'd1, 1'b0, 32'(i + 2));
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_z", out_z, 32'd0);
        chk("async_issued", issued, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single op latency: accepted at edge t, result visible after edge t+1
        out_ready = 1'b1;
        send(32'd7, 32'd5, 1'b0, 32'd12);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_z", out_z, 32'd12);
        send(32'd7, 32'd5, 1'b1, 32'd2);
        drain();
        chk("issued_2", issued, 32'd2);

        // wrap-around arithmetic
        send(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000);
        send(32'd0, 32'd1, 1'b1, 32'hFFFFFFFF);
        drain();

        // backpressure: 1 in the output register + 4 in the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(100 + i), 32'(i), 1'b0, 32'(100 + 2 * i));
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_z", out_z, 32'd100);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_one_per_cycle", 32'(out_valid), 32'd1);
        end
        drain();

        // streaming: 16 back-to-back requests, alternating op
        s5 = 1'b1;
        for (int i = 0; i < 16; i++)
            send(32'(2 * i), 32'(i), i[0], i[0] ? 32'(i) : 32'(3 * i));
        drain();
        s5 = 1'b0;
        chk("stream_max_occ", 32'(max_occ), 32'd1);
        chk("stream_run", 32'(max_run), 32'd16);
        chk("stream_issued", issued, 32'd25);

        // push+pop same cycle at occupancy 2 across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(i * 1000), 32'd7, 1'b1, 32'(i * 1000 - 7));
        chk("pp_occ_start", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        for (int i = 3; i < 10; i++) begin
            send(32'(i * 1000), 32'd7, 1'b1, 32'(i * 1000 - 7));
            chk("pp_occ", 32'(occupancy), 32'd2);
        end
        drain();
        chk("end_occ", 32'(occupancy), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_hold_z", out_z, 32'd8993);
        chk("end_issued", issued, 32'd35);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
